// File: rtl/tsim_mem_responder_if.sv
// Accelerator memory protocol bundle: request, write-beat and read-beat channels.
// Latency: none (wires only).
// Backpressure: only the read channel is flow controlled (mem_rd_ready); writes are never stalled.
//
// master : accelerator side (issues requests, pushes write beats, consumes read beats)
// slave  : responder side (tsim_mem_responder)
interface tsim_mem_responder_if #(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 64,
    parameter int MEM_DATA_BITS = 64
);
    logic                     mem_req_valid;
    logic                     mem_req_opcode;
    logic [MEM_LEN_BITS-1:0]  mem_req_len;
    logic [MEM_ADDR_BITS-1:0] mem_req_addr;
    logic                     mem_wr_valid;
    logic [MEM_DATA_BITS-1:0] mem_wr_bits;
    logic                     mem_rd_valid;
    logic [MEM_DATA_BITS-1:0] mem_rd_bits;
    logic                     mem_rd_ready;

    modport master (
        output mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
        output mem_wr_valid, mem_wr_bits, mem_rd_ready,
        input  mem_rd_valid, mem_rd_bits
    );

    modport slave (
        input  mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
        input  mem_wr_valid, mem_wr_bits, mem_rd_ready,
        output mem_rd_valid, mem_rd_bits
    );
endinterface

// File: rtl/tsim_mem_responder.sv
// On-chip RAM answering the accelerator memory protocol (stand-in for the DPI memory model).
// Latency: first read beat valid 1 cycle after the accepted request, then one beat per cycle.
// Backpressure: read beats held stable until mem_rd_ready; write beats are absorbed without stall.
//
// Ports:
//   clock, reset      single rising-edge clock, asynchronous active-high reset
//   mem (slave)       req / wr / rd channels of the accelerator memory protocol
//   busy              registered, high whenever a burst is in progress
//   err               sticky flag: request while busy, or write beat outside a write burst
//   bd_we/addr/wdata  backdoor word write (any state; a same-word protocol write wins)
//   bd_rdata          combinational backdoor read of RAM[bd_addr]
//   stat_rd_beats     read handshakes delivered   (only with TSIM_MEM_STATS_EN, else 0)
//   stat_wr_beats     write beats absorbed        (only with TSIM_MEM_STATS_EN, else 0)
//
// Optional macro: TSIM_MEM_STATS_EN enables the two 32-bit wrapping beat counters.
module tsim_mem_responder #(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 64,
    parameter int MEM_DATA_BITS = 64,
    parameter int DEPTH_LOG2    = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    tsim_mem_responder_if.slave      mem,
    output logic                     busy,
    output logic                     err,
    input  logic                     bd_we,
    input  logic [DEPTH_LOG2-1:0]    bd_addr,
    input  logic [MEM_DATA_BITS-1:0] bd_wdata,
    output logic [MEM_DATA_BITS-1:0] bd_rdata,
    output logic [31:0]              stat_rd_beats,
    output logic [31:0]              stat_wr_beats
);
    // Byte address -> word index shift.
    localparam int OFF = $clog2(MEM_DATA_BITS / 8);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    logic [MEM_DATA_BITS-1:0] ram [2**DEPTH_LOG2];

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic [DEPTH_LOG2-1:0]    ptr;
    logic [DEPTH_LOG2-1:0]    ptr_inc;
    logic [DEPTH_LOG2-1:0]    req_ptr;
    logic [MEM_LEN_BITS-1:0]  cnt;
    logic                     rd_valid_q;
    logic [MEM_DATA_BITS-1:0] rd_bits_q;

    logic req_acc;
    logic rd_hs;
    logic wr_beat;
    logic last;
    logic unused_addr;

    // Upper address bits and the byte-offset bits are dropped; the pointer
    // wraps within the RAM depth.
    assign req_ptr     = mem.mem_req_addr[OFF +: DEPTH_LOG2];
    assign unused_addr = ^mem.mem_req_addr;
    assign ptr_inc     = ptr + DEPTH_LOG2'(1);

    assign req_acc = (state == ST_IDLE) && mem.mem_req_valid;
    assign rd_hs   = (state == ST_READ) && rd_valid_q && mem.mem_rd_ready;
    assign wr_beat = (state == ST_WRITE) && mem.mem_wr_valid;
    assign last    = (cnt == '0);

    assign mem.mem_rd_valid = rd_valid_q;
    assign mem.mem_rd_bits  = rd_bits_q;
    assign bd_rdata         = ram[bd_addr];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (mem.mem_req_valid) state_nxt = mem.mem_req_opcode ? ST_WRITE : ST_READ;
            ST_READ:  if (rd_hs && last)     state_nxt = ST_IDLE;
            ST_WRITE: if (wr_beat && last)   state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            err        <= 1'b0;
            ptr        <= '0;
            cnt        <= '0;
            rd_valid_q <= 1'b0;
            rd_bits_q  <= '0;
        end else begin
            state <= state_nxt;
            // busy is the registered image of the next state, so it tracks state exactly.
            busy  <= (state_nxt != ST_IDLE);

            if (req_acc) begin
                ptr <= req_ptr;
                cnt <= mem.mem_req_len;
                if (!mem.mem_req_opcode) begin
                    // Fetch the first beat now so it is valid on the next cycle.
                    rd_bits_q  <= ram[req_ptr];
                    rd_valid_q <= 1'b1;
                end
            end

            if (rd_hs) begin
                if (last) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    cnt       <= cnt - MEM_LEN_BITS'(1);
                    ptr       <= ptr_inc;
                    rd_bits_q <= ram[ptr_inc];
                end
            end

            if (wr_beat && !last) begin
                cnt <= cnt - MEM_LEN_BITS'(1);
                ptr <= ptr_inc;
            end

            if ((mem.mem_wr_valid && state != ST_WRITE) ||
                (mem.mem_req_valid && state != ST_IDLE)) begin
                err <= 1'b1;
            end
        end
    end

    // Backdoor is written first so a same-word protocol write overrides it.
    // No protocol write can occur during reset because state is forced to IDLE.
    always_ff @(posedge clock) begin
        if (bd_we)   ram[bd_addr] <= bd_wdata;
        if (wr_beat) ram[ptr]     <= mem.mem_wr_bits;
    end

`ifdef TSIM_MEM_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_hs)   rd_cnt_q <= rd_cnt_q + 32'd1;
            if (wr_beat) wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    assign stat_rd_beats = rd_cnt_q;
    assign stat_wr_beats = wr_cnt_q;
`else
    assign stat_rd_beats = 32'd0;
    assign stat_wr_beats = 32'd0;
`endif

endmodule

// File: tb/tb_tsim_mem_responder.sv
// Directed bench for tsim_mem_responder: reset, read burst, gapped write burst,
// read backpressure, pointer wrap, protocol errors and reset mid-burst.
module tb_tsim_mem_responder;
    localparam int LB = 8;
    localparam int AB = 64;
    localparam int DB = 64;
    localparam int DL = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          busy;
    logic          err;
    logic          bd_we = 1'b0;
    logic [DL-1:0] bd_addr = '0;
    logic [DB-1:0] bd_wdata = '0;
    logic [DB-1:0] bd_rdata;
    logic [31:0]   stat_rd_beats;
    logic [31:0]   stat_wr_beats;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [DB-1:0] DA = 64'h0000_0000_A1A1_A1A1;
    localparam logic [DB-1:0] DBV = 64'h0000_0000_B2B2_B2B2;
    localparam logic [DB-1:0] DC = 64'h0000_0000_C3C3_C3C3;
    localparam logic [DB-1:0] DD = 64'h0000_0000_D4D4_D4D4;

    tsim_mem_responder_if #(.MEM_LEN_BITS(LB), .MEM_ADDR_BITS(AB), .MEM_DATA_BITS(DB)) mem_bus ();

    tsim_mem_responder #(
        .MEM_LEN_BITS(LB), .MEM_ADDR_BITS(AB), .MEM_DATA_BITS(DB), .DEPTH_LOG2(DL)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mem           (mem_bus),
        .busy          (busy),
        .err           (err),
        .bd_we         (bd_we),
        .bd_addr       (bd_addr),
        .bd_wdata      (bd_wdata),
        .bd_rdata      (bd_rdata),
        .stat_rd_beats (stat_rd_beats),
        .stat_wr_beats (stat_wr_beats)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic bd_write(input logic [DL-1:0] a, input logic [DB-1:0] d);
        bd_addr  = a;
        bd_wdata = d;
        bd_we    = 1'b1;
        step();
        bd_we    = 1'b0;
    endtask

    task automatic issue_req(input logic op, input logic [AB-1:0] a, input logic [LB-1:0] l);
        mem_bus.mem_req_valid  = 1'b1;
        mem_bus.mem_req_opcode = op;
        mem_bus.mem_req_addr   = a;
        mem_bus.mem_req_len    = l;
        step();
        mem_bus.mem_req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        mem_bus.mem_req_valid  = 1'b0;
        mem_bus.mem_req_opcode = 1'b0;
        mem_bus.mem_req_addr   = '0;
        mem_bus.mem_req_len    = '0;
        mem_bus.mem_wr_valid   = 1'b0;
        mem_bus.mem_wr_bits    = '0;
        mem_bus.mem_rd_ready   = 1'b0;
        reset = 1'b1;
        step();
        step();
        n_checks++; if (mem_bus.mem_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %0h want 0", mem_bus.mem_rd_valid); end
        n_checks++; if (mem_bus.mem_rd_bits !== '0) begin n_fail++; $display("FAIL reset_rd_bits got %0h want 0", mem_bus.mem_rd_bits); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0h want 0", busy); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0h want 0", err); end
        n_checks++; if (stat_rd_beats !== 32'd0 || stat_wr_beats !== 32'd0) begin n_fail++; $display("FAIL reset_stats got %0h/%0h want 0/0", stat_rd_beats, stat_wr_beats); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_read_burst();
        logic [DB-1:0] exp [3];
        exp[0] = 64'h22; exp[1] = 64'h33; exp[2] = 64'h44;
        bd_write(10'd0, 64'h11);
        bd_write(10'd1, 64'h22);
        bd_write(10'd2, 64'h33);
        bd_write(10'd3, 64'h44);
        bd_addr = 10'd2; #1;
        n_checks++; if (bd_rdata !== 64'h33) begin n_fail++; $display("FAIL bd_preload got %0h want 33", bd_rdata); end
        mem_bus.mem_rd_ready = 1'b1;
        issue_req(1'b0, 64'h8, 8'd2);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (mem_bus.mem_rd_valid !== 1'b1 || mem_bus.mem_rd_bits !== exp[i]) begin n_fail++; $display("FAIL read_beat%0d got v=%0h d=%0h want v=1 d=%0h", i, mem_bus.mem_rd_valid, mem_bus.mem_rd_bits, exp[i]); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL read_busy%0d got %0h want 1", i, busy); end
            step();
        end
        n_checks++; if (mem_bus.mem_rd_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL read_end got v=%0h busy=%0h want 0/0", mem_bus.mem_rd_valid, busy); end
    endtask

    task automatic test_write_gapped();
        logic          pat [5];
        logic [DB-1:0] dat [5];
        logic [DB-1:0] exp [4];
        pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 1;
        dat[0] = DA; dat[1] = 64'hFFFF; dat[2] = DBV; dat[3] = DC; dat[4] = DD;
        exp[0] = DA; exp[1] = DBV; exp[2] = DC; exp[3] = DD;
        issue_req(1'b1, 64'h0, 8'd3);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy got %0h want 1", busy); end
        for (int i = 0; i < 5; i++) begin
            mem_bus.mem_wr_valid = pat[i];
            mem_bus.mem_wr_bits  = dat[i];
            step();
            if (i == 3) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_before_last got %0h want 1", busy); end
            end
        end
        mem_bus.mem_wr_valid = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_idle got busy=%0h want 0", busy); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL write_err got %0h want 0", err); end
        for (int i = 0; i < 4; i++) begin
            bd_addr = DL'(i); #1;
            n_checks++; if (bd_rdata !== exp[i]) begin n_fail++; $display("FAIL write_word%0d got %0h want %0h", i, bd_rdata, exp[i]); end
        end
    endtask

    task automatic test_backpressure();
        mem_bus.mem_rd_ready = 1'b0;
        issue_req(1'b0, 64'h0, 8'd1);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (mem_bus.mem_rd_valid !== 1'b1 || mem_bus.mem_rd_bits !== DA) begin n_fail++; $display("FAIL bp_hold%0d got v=%0h d=%0h want v=1 d=%0h", i, mem_bus.mem_rd_valid, mem_bus.mem_rd_bits, DA); end
            step();
        end
        mem_bus.mem_rd_ready = 1'b1;
        step();
        n_checks++; if (mem_bus.mem_rd_valid !== 1'b1 || mem_bus.mem_rd_bits !== DBV) begin n_fail++; $display("FAIL bp_beat2 got v=%0h d=%0h want v=1 d=%0h", mem_bus.mem_rd_valid, mem_bus.mem_rd_bits, DBV); end
        step();
        n_checks++; if (mem_bus.mem_rd_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_end got v=%0h busy=%0h want 0/0", mem_bus.mem_rd_valid, busy); end
    endtask

    task automatic test_wrap();
        bd_write(10'd1023, 64'hAA);
        bd_write(10'd0, 64'hBB);
        mem_bus.mem_rd_ready = 1'b1;
        issue_req(1'b0, 64'd8184, 8'd1);
        n_checks++; if (mem_bus.mem_rd_valid !== 1'b1 || mem_bus.mem_rd_bits !== 64'hAA) begin n_fail++; $display("FAIL wrap_beat0 got v=%0h d=%0h want v=1 d=aa", mem_bus.mem_rd_valid, mem_bus.mem_rd_bits); end
        step();
        n_checks++; if (mem_bus.mem_rd_valid !== 1'b1 || mem_bus.mem_rd_bits !== 64'hBB) begin n_fail++; $display("FAIL wrap_beat1 got v=%0h d=%0h want v=1 d=bb", mem_bus.mem_rd_valid, mem_bus.mem_rd_bits); end
        step();
        n_checks++; if (mem_bus.mem_rd_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_end got v=%0h want 0", mem_bus.mem_rd_valid); end
    endtask

    task automatic test_errors();
        logic [DB-1:0] exp [4];
        exp[0] = 64'h55; exp[1] = 64'h66; exp[2] = 64'h77; exp[3] = 64'h88;
        for (int i = 0; i < 4; i++) bd_write(DL'(4 + i), exp[i]);
        mem_bus.mem_rd_ready = 1'b1;
        issue_req(1'b0, 64'd32, 8'd3);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mem_bus.mem_rd_valid !== 1'b1 || mem_bus.mem_rd_bits !== exp[i]) begin n_fail++; $display("FAIL err_beat%0d got v=%0h d=%0h want v=1 d=%0h", i, mem_bus.mem_rd_valid, mem_bus.mem_rd_bits, exp[i]); end
            if (i == 0) begin
                // Stray write request while the read burst is running.
                mem_bus.mem_req_valid  = 1'b1;
                mem_bus.mem_req_opcode = 1'b1;
                mem_bus.mem_req_addr   = 64'h0;
                mem_bus.mem_req_len    = 8'd0;
            end
            step();
            mem_bus.mem_req_valid = 1'b0;
            if (i == 0) begin
                n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_req_in_read got %0h want 1", err); end
            end
        end
        n_checks++; if (mem_bus.mem_rd_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL err_burst_end got v=%0h busy=%0h want 0/0", mem_bus.mem_rd_valid, busy); end
        mem_bus.mem_wr_valid = 1'b1;
        mem_bus.mem_wr_bits  = 64'hDEAD;
        step();
        mem_bus.mem_wr_valid = 1'b0;
        step();
        n_checks++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL err_sticky got err=%0h busy=%0h want 1/0", err, busy); end
        bd_addr = 10'd7; #1;
        n_checks++; if (bd_rdata !== 64'h88) begin n_fail++; $display("FAIL err_word7 got %0h want 88", bd_rdata); end
        bd_addr = 10'd0; #1;
        n_checks++; if (bd_rdata !== 64'hBB) begin n_fail++; $display("FAIL err_word0 got %0h want bb", bd_rdata); end
        bd_addr = 10'd1; #1;
        n_checks++; if (bd_rdata !== DBV) begin n_fail++; $display("FAIL err_word1 got %0h want %0h", bd_rdata, DBV); end
    endtask

    task automatic test_reset_mid_read();
        for (int i = 0; i < 4; i++) bd_write(DL'(8 + i), 64'h81 + 64'(i));
        mem_bus.mem_rd_ready = 1'b1;
        issue_req(1'b0, 64'd64, 8'd3);
        n_checks++; if (mem_bus.mem_rd_bits !== 64'h81) begin n_fail++; $display("FAIL rst_mid_beat1 got %0h want 81", mem_bus.mem_rd_bits); end
        step();
        n_checks++; if (mem_bus.mem_rd_bits !== 64'h82) begin n_fail++; $display("FAIL rst_mid_beat2 got %0h want 82", mem_bus.mem_rd_bits); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (mem_bus.mem_rd_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async got v=%0h busy=%0h want 0/0", mem_bus.mem_rd_valid, busy); end
        n_checks++; if (err !== 1'b0 || stat_rd_beats !== 32'd0 || stat_wr_beats !== 32'd0) begin n_fail++; $display("FAIL rst_mid_clear got err=%0h rd=%0h wr=%0h want 0", err, stat_rd_beats, stat_wr_beats); end
        @(negedge clock);
        step();
        reset = 1'b0;
        step();
        n_checks++; if (mem_bus.mem_rd_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_beats got v=%0h busy=%0h want 0/0", mem_bus.mem_rd_valid, busy); end
        issue_req(1'b0, 64'd64, 8'd0);
        n_checks++; if (mem_bus.mem_rd_valid !== 1'b1 || mem_bus.mem_rd_bits !== 64'h81) begin n_fail++; $display("FAIL rst_mid_reread got v=%0h d=%0h want v=1 d=81", mem_bus.mem_rd_valid, mem_bus.mem_rd_bits); end
        step();
        n_checks++; if (mem_bus.mem_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_reread_end got v=%0h want 0", mem_bus.mem_rd_valid); end
`ifdef TSIM_MEM_STATS_EN
        n_checks++; if (stat_rd_beats !== 32'd1 || stat_wr_beats !== 32'd0) begin n_fail++; $display("FAIL stats_after got rd=%0d wr=%0d want 1/0", stat_rd_beats, stat_wr_beats); end
`else
        n_checks++; if (stat_rd_beats !== 32'd0 || stat_wr_beats !== 32'd0) begin n_fail++; $display("FAIL stats_off got rd=%0d wr=%0d want 0/0", stat_rd_beats, stat_wr_beats); end
`endif
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_write_gapped();
        test_backpressure();
        test_wrap();
        test_errors();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
